pulse_generator_core: RTL and testbench

//  Consumes the programmed values of one pulse-generator register bank and drives
//  one timing pulse output. Waits for wall-clock time (from the RTC/GPS time block)
//  to equal the programmed start time on a PPS edge. From then on, emits a periodic

---
 rtl/pulse_generator_core.sv | 145 ++++++++++++++
 tb/tb_pulse_generator_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_generator_core.sv
// Timing pulse generator for one register bank: arms on enable, starts on a PPS edge
// matching the programmed start time, then emits a us-tick counted periodic pulse.
// Optional PG_PULSE_COUNT_EN adds o_pulse_count (saturating rising-edge counter).
module pulse_generator_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int ENA_BIT    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_us_tick,
  input  logic                  i_pps,
  input  logic [DATA_WIDTH-1:0] i_year_h,
  input  logic [DATA_WIDTH-1:0] i_year_l,
  input  logic [DATA_WIDTH-1:0] i_month,
  input  logic [DATA_WIDTH-1:0] i_day,
  input  logic [DATA_WIDTH-1:0] i_hour,
  input  logic [DATA_WIDTH-1:0] i_minutes,
  input  logic [DATA_WIDTH-1:0] i_seconds,
  input  logic [DATA_WIDTH-1:0] i_pulse_enable,
  input  logic [DATA_WIDTH-1:0] i_usr_year_h,
  input  logic [DATA_WIDTH-1:0] i_usr_year_l,
  input  logic [DATA_WIDTH-1:0] i_usr_month,
  input  logic [DATA_WIDTH-1:0] i_usr_day,
  input  logic [DATA_WIDTH-1:0] i_usr_hour,
  input  logic [DATA_WIDTH-1:0] i_usr_minutes,
  input  logic [DATA_WIDTH-1:0] i_usr_seconds,
  input  logic [DATA_WIDTH-1:0] i_width_high_3,
  input  logic [DATA_WIDTH-1:0] i_width_high_2,
  input  logic [DATA_WIDTH-1:0] i_width_high_1,
  input  logic [DATA_WIDTH-1:0] i_width_high_0,
  input  logic [DATA_WIDTH-1:0] i_width_period_3,
  input  logic [DATA_WIDTH-1:0] i_width_period_2,
  input  logic [DATA_WIDTH-1:0] i_width_period_1,
  input  logic [DATA_WIDTH-1:0] i_width_period_0,
  output logic                  o_pulse,
  output logic                  o_armed,
  output logic                  o_running,
  output logic                  o_cfg_err
`ifdef PG_PULSE_COUNT_EN
  ,
  output logic [15:0]           o_pulse_count
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] shadow_width, shadow_period, cnt, cnt_next;
  logic [CNT_WIDTH-1:0] width_in, period_in;
  logic                 en, match, trigger;
  logic                 unused;

  assign en = i_pulse_enable[ENA_BIT];
  assign unused = &{1'b0, i_pulse_enable};

  assign match = (i_year_h  == i_usr_year_h)  && (i_year_l  == i_usr_year_l) &&
                 (i_month   == i_usr_month)   && (i_day     == i_usr_day)    &&
                 (i_hour    == i_usr_hour)    && (i_minutes == i_usr_minutes) &&
                 (i_seconds == i_usr_seconds);

  assign width_in  = CNT_WIDTH'({i_width_high_3, i_width_high_2, i_width_high_1, i_width_high_0});
  assign period_in = CNT_WIDTH'({i_width_period_3, i_width_period_2,
                                 i_width_period_1, i_width_period_0});

  assign trigger = i_pps && match && (shadow_period != '0);

  always_comb begin
    cnt_next = cnt;
    if (i_us_tick)
      cnt_next = (cnt == shadow_period - CNT_WIDTH'(1)) ? '0 : cnt + CNT_WIDTH'(1);
  end

  // o_pulse tracks (cnt < width) of the registered counter, so it moves on the
  // same edge as the counter: one cycle after the trigger or tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_pulse       <= 1'b0;
      o_armed       <= 1'b0;
      o_running     <= 1'b0;
      o_cfg_err     <= 1'b0;
      cnt           <= '0;
      shadow_width  <= '0;
      shadow_period <= '0;
    end else if (!en) begin
      state     <= IDLE;
      o_pulse   <= 1'b0;
      o_armed   <= 1'b0;
      o_running <= 1'b0;
      o_cfg_err <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state         <= ARMED;
          o_armed       <= 1'b1;
          o_pulse       <= 1'b0;
          shadow_width  <= width_in;
          shadow_period <= period_in;
          o_cfg_err     <= (period_in == '0);
        end
        ARMED: begin
          o_pulse <= 1'b0;
          if (trigger) begin
            state     <= RUN;
            o_armed   <= 1'b0;
            o_running <= 1'b1;
            cnt       <= '0;
            o_pulse   <= (shadow_width != '0);
          end
        end
        RUN: begin
          cnt     <= cnt_next;
          o_pulse <= (cnt_next < shadow_width);
        end
        default: begin
          state     <= IDLE;
          o_pulse   <= 1'b0;
          o_armed   <= 1'b0;
          o_running <= 1'b0;
          o_cfg_err <= 1'b0;
        end
      endcase
    end
  end

`ifdef PG_PULSE_COUNT_EN
  logic pulse_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pulse_prev    <= 1'b0;
      o_pulse_count <= '0;
    end else begin
      pulse_prev <= o_pulse;
      if (state == IDLE && en)
        o_pulse_count <= '0;
      else if (o_pulse && !pulse_prev && o_pulse_count != 16'hFFFF)
        o_pulse_count <= o_pulse_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_generator_core.sv
// Directed self-checking bench for pulse_generator_core.
module tb_pulse_generator_core;

  logic       clk = 1'b0;
  logic       rst, us_tick, pps;
  logic [7:0] year_h, year_l, month, day, hour, minutes, seconds, pulse_enable;
  logic [7:0] usr_year_h, usr_year_l, usr_month, usr_day, usr_hour, usr_minutes, usr_seconds;
  logic [7:0] wh3, wh2, wh1, wh0, wp3, wp2, wp1, wp0;
  logic       pulse, armed, running, cfg_err;
`ifdef PG_PULSE_COUNT_EN
  logic [15:0] pulse_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_generator_core #(.DATA_WIDTH(8), .CNT_WIDTH(32), .ENA_BIT(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_us_tick(us_tick), .i_pps(pps),
    .i_year_h(year_h), .i_year_l(year_l), .i_month(month), .i_day(day),
    .i_hour(hour), .i_minutes(minutes), .i_seconds(seconds),
    .i_pulse_enable(pulse_enable),
    .i_usr_year_h(usr_year_h), .i_usr_year_l(usr_year_l), .i_usr_month(usr_month),
    .i_usr_day(usr_day), .i_usr_hour(usr_hour), .i_usr_minutes(usr_minutes),
    .i_usr_seconds(usr_seconds),
    .i_width_high_3(wh3), .i_width_high_2(wh2), .i_width_high_1(wh1), .i_width_high_0(wh0),
    .i_width_period_3(wp3), .i_width_period_2(wp2), .i_width_period_1(wp1),
    .i_width_period_0(wp0),
    .o_pulse(pulse), .o_armed(armed), .o_running(running), .o_cfg_err(cfg_err)
`ifdef PG_PULSE_COUNT_EN
    , .o_pulse_count(pulse_count)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    us_tick = 1'b1; step(); us_tick = 1'b0; step();
  endtask

  task automatic set_regs(input logic [31:0] w, input logic [31:0] p);
    {wh3, wh2, wh1, wh0} = w;
    {wp3, wp2, wp1, wp0} = p;
  endtask

  task automatic chk_state(input string name, input logic ep, input logic ea,
                           input logic er, input logic ec);
    tests++;
    if ({pulse, armed, running, cfg_err} !== {ep, ea, er, ec}) begin
      fails++;
      $display("FAIL %s: pulse/armed/running/cfg_err got %b%b%b%b want %b%b%b%b",
               name, pulse, armed, running, cfg_err, ep, ea, er, ec);
    end
  endtask

  // Re-arm from scratch with the given registers, then fire a matching PPS.
  task automatic arm_and_fire(input logic [31:0] w, input logic [31:0] p);
    pulse_enable = 8'h00; step();
    set_regs(w, p);
    pulse_enable = 8'h01; step();
    pps = 1'b1; step(); pps = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    chk_state("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; step();
    chk_state("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    logic [9:0] pat;
    logic       mism;
    pat = 10'b1110000000;
    seconds = 8'd29;
    set_regs(32'd3, 32'd10);
    pulse_enable = 8'h01; step();
    chk_state("armed", 1'b0, 1'b1, 1'b0, 1'b0);
    pps = 1'b1; step(); pps = 1'b0;
    chk_state("pps_no_match", 1'b0, 1'b1, 1'b0, 1'b0);
    seconds = 8'd30; step(); step();
    chk_state("match_no_pps", 1'b0, 1'b1, 1'b0, 1'b0);
    pps = 1'b1; step(); pps = 1'b0;
    chk_state("trigger", 1'b1, 1'b0, 1'b1, 1'b0);
    mism = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pulse !== pat[9 - (k % 10)]) mism = 1'b1;
    end
    tests++;
    if (mism) begin
      fails++;
      $display("FAIL basic_waveform: pulse got %b at end, want 3-high/7-low pattern", pulse);
    end
  endtask

  task automatic test_boundaries();
    logic mism;
    arm_and_fire(32'd10, 32'd10);
    mism = (pulse !== 1'b1) || (running !== 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pulse !== 1'b1) mism = 1'b1;
    end
    tests++;
    if (mism) begin fails++; $display("FAIL width_eq_period: pulse got %b want 1", pulse); end
    arm_and_fire(32'd0, 32'd10);
    mism = (pulse !== 1'b0) || (running !== 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pulse !== 1'b0) mism = 1'b1;
    end
    tests++;
    if (mism) begin fails++; $display("FAIL width_zero: pulse got %b want 0", pulse); end
  endtask

  task automatic test_cfg_err();
    pulse_enable = 8'h00; step();
    set_regs(32'd3, 32'd0);
    pulse_enable = 8'h01; step();
    chk_state("cfg_err_armed", 1'b0, 1'b1, 1'b0, 1'b1);
    pps = 1'b1; step(); pps = 1'b0;
    chk_state("cfg_err_no_run", 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_enable = 8'h00; step();
    chk_state("cfg_err_clear", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_disable();
    arm_and_fire(32'd3, 32'd10);
    chk_state("dis_run", 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_enable = 8'h00; step();
    chk_state("dis_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_enable = 8'h01; step();
    pulse_enable = 8'h00; pps = 1'b1; step(); pps = 1'b0;
    chk_state("dis_beats_trigger", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("dis_stays_idle", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_catchup();
    pulse_enable = 8'h00; step();
    set_regs(32'd3, 32'd10);
    seconds = 8'd31;
    pulse_enable = 8'h01; step();
    pps = 1'b1; step(); pps = 1'b0;
    step();
    chk_state("past_start", 1'b0, 1'b1, 1'b0, 1'b0);
    seconds = 8'd30;
  endtask

  task automatic test_shadow();
    logic mism;
    arm_and_fire(32'd3, 32'd10);
    set_regs(32'd8, 32'd10);
    mism = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pulse !== ((k % 10) < 3)) mism = 1'b1;
    end
    tests++;
    if (mism) begin fails++; $display("FAIL shadow_hold: pulse got %b, width change leaked", pulse); end
    arm_and_fire(32'd8, 32'd10);
    mism = (pulse !== 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pulse !== ((k % 10) < 8)) mism = 1'b1;
    end
    tests++;
    if (mism) begin fails++; $display("FAIL rearm_width8: pulse got %b want 8-high pattern", pulse); end
  endtask

  task automatic test_reset_mid_run();
    arm_and_fire(32'd3, 32'd10);
    tick();
    chk_state("pre_rst_high", 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; step();
    chk_state("rst_mid_run", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
`ifdef PG_PULSE_COUNT_EN
    arm_and_fire(32'd3, 32'd10);
    for (int k = 0; k < 40; k++) tick();
    tests++;
    if (pulse_count !== 16'd5) begin
      fails++; $display("FAIL pulse_count: got %0d want 5", pulse_count);
    end
    rst = 1'b1; step(); rst = 1'b0;
    tests++;
    if (pulse_count !== 16'd0) begin
      fails++; $display("FAIL pulse_count_reset: got %0d want 0", pulse_count);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; us_tick = 1'b0; pps = 1'b0; pulse_enable = 8'h00;
    year_h = 8'd20; year_l = 8'd24; month = 8'd3; day = 8'd5;
    hour = 8'd10; minutes = 8'd20; seconds = 8'd0;
    usr_year_h = 8'd20; usr_year_l = 8'd24; usr_month = 8'd3; usr_day = 8'd5;
    usr_hour = 8'd10; usr_minutes = 8'd20; usr_seconds = 8'd30;
    set_regs(32'd0, 32'd0);
    test_reset();
    test_basic();
    test_boundaries();
    test_cfg_err();
    test_disable();
    test_no_catchup();
    test_shadow();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
